intpol2_d4_seq: RTL and testbench



---
 rtl/intpol2_D4_pkg.sv | 36 +++
 rtl/intpol2_D4_coef.sv | 60 ++++++
 rtl/intpol2_d4_seq.sv | 163 ++++++++++++++++
 tb/tb_intpol2_d4_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intpol2_D4_pkg.sv
// Shared types and constants for the interpolate-by-4 quadratic sequencer.
package intpol2_D4_pkg;

   // Sequencer states: fill the window, wait for a sample, latch coefficients, issue phases
   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_IDLE  = 2'd1,
      ST_COEF  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   // Select codes understood by the squared block: xi2 = 0, x2, 4*x2, 9*x2
   localparam logic [1:0] SEL_ZERO = 2'b00;
   localparam logic [1:0] SEL_X    = 2'b01;
   localparam logic [1:0] SEL_SHL2 = 2'b10;
   localparam logic [1:0] SEL_REC  = 2'b11;

   // Interpolation factor: phases k = 0..PHASES-1 per input sample
   localparam int PHASES = 4;

   // Extra bits on the linear coefficient so 8*d1 - 4*d2 is exact
   localparam int C1_HEADROOM = 5;

   // Map phase index k to the select that yields k*k*x2 downstream
   function automatic logic [1:0] phase_sel(input logic [1:0] k);
      logic [1:0] sel;
      case (k)
         2'd0:    sel = SEL_ZERO;
         2'd1:    sel = SEL_X;
         2'd2:    sel = SEL_SHL2;
         default: sel = SEL_REC;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/intpol2_D4_coef.sv
// Coefficient register: second difference x2, base y0 and linear term c1,
// computed from the 3-sample window and captured when i_load is high.
module intpol2_D4_coef
   import intpol2_D4_pkg::*;
#(
   parameter int W      = 32,
   parameter int N_bits = 2
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            i_load,
   input  logic signed [W-1:0]             i_y0,
   input  logic signed [W-1:0]             i_y1,
   input  logic signed [W-1:0]             i_y2,
   output logic signed [W+N_bits-1:0]      o_x2,
   output logic signed [W-1:0]             o_y0,
   output logic signed [W+C1_HEADROOM-1:0] o_c1
);

   localparam int CW = W + C1_HEADROOM;
   localparam int XW = W + N_bits;

   // All arithmetic is done at the c1 width; d1 needs W+1 bits, d2 needs W+2,
   // and 8*d1 - 4*d2 needs W+5, so nothing here can overflow.
   logic signed [CW-1:0] w_y0_ext;
   logic signed [CW-1:0] w_y1_ext;
   logic signed [CW-1:0] w_y2_ext;
   logic signed [CW-1:0] w_d1;
   logic signed [CW-1:0] w_d2;
   logic signed [CW-1:0] w_c1;

   logic signed [XW-1:0] r_x2;
   logic signed [W-1:0]  r_y0;
   logic signed [CW-1:0] r_c1;

   assign w_y0_ext = CW'(i_y0);
   assign w_y1_ext = CW'(i_y1);
   assign w_y2_ext = CW'(i_y2);
   assign w_d1     = w_y1_ext - w_y0_ext;
   assign w_d2     = w_y0_ext - (w_y1_ext <<< 1) + w_y2_ext;
   assign w_c1     = (w_d1 <<< 3) - (w_d2 <<< 2);

   // Capture coefficients on load; they stay put until the next load
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_x2 <= '0;
         r_y0 <= '0;
         r_c1 <= '0;
      end else if (i_load) begin
         r_x2 <= XW'(w_d2);
         r_y0 <= i_y0;
         r_c1 <= w_c1;
      end
   end

   assign o_x2 = r_x2;
   assign o_y0 = r_y0;
   assign o_c1 = r_c1;

endmodule

// File: rtl/intpol2_d4_seq.sv
// Sequencer and coefficient front-end for the interpolate-by-4 quadratic
// datapath: keeps a 3-sample window, latches coefficients per sample and
// steps the squared block through four phases with a valid/ready output.
module intpol2_d4_seq
   import intpol2_D4_pkg::*;
#(
   parameter int DATAPATH_WIDTH = 32,
   parameter int N_bits         = 2   // must be at least 2 to hold d2 exactly
) (
   input  logic                                         clk,
   input  logic                                         rstn,
   input  logic                                         clear,
   input  logic                                         s_valid,
   output logic                                         s_ready,
   input  logic signed [DATAPATH_WIDTH-1:0]             s_data,
   output logic                                         en_xi2,
   output logic [1:0]                                   sel_xi2,
   output logic signed [DATAPATH_WIDTH+N_bits-1:0]      x2,
   output logic                                         m_valid,
   input  logic                                         m_ready,
   output logic [1:0]                                   phase_o,
   output logic signed [DATAPATH_WIDTH-1:0]             y0_o,
   output logic signed [DATAPATH_WIDTH+C1_HEADROOM-1:0] c1_o
);

   localparam int W = DATAPATH_WIDTH;
   localparam logic [1:0] K_LAST = 2'(PHASES - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [1:0]      r_k;
   logic [1:0]      w_k_next;
   logic            r_cnt;        // samples taken so far while priming (0 or 1)
   logic            w_cnt_next;

   logic signed [W-1:0] r_y0;
   logic signed [W-1:0] r_y1;
   logic signed [W-1:0] r_y2;

   logic            r_m_valid;
   logic [1:0]      r_phase;

   logic            w_accept;
   logic            w_issue;
   logic            w_load;

   // Handshake decode: clear overrides both a pending sample and a pending issue
   always_comb begin
      s_ready  = (r_state == ST_PRIME) || (r_state == ST_IDLE);
      w_accept = s_valid && s_ready && !clear;
      w_issue  = (r_state == ST_RUN) && (!r_m_valid || m_ready) && !clear;
      w_load   = (r_state == ST_COEF) && !clear;
      en_xi2   = w_issue;
      sel_xi2  = w_issue ? phase_sel(r_k) : SEL_ZERO;
   end

   // Next-state logic for the sequencer, phase counter and priming counter
   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      w_cnt_next   = r_cnt;
      if (clear) begin
         w_state_next = ST_PRIME;
         w_k_next     = 2'd0;
         w_cnt_next   = 1'b0;
      end else begin
         case (r_state)
            ST_PRIME: begin
               if (w_accept) begin
                  if (r_cnt) begin
                     w_state_next = ST_IDLE;
                     w_cnt_next   = 1'b0;
                  end else begin
                     w_cnt_next   = 1'b1;
                  end
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  w_state_next = ST_COEF;
               end
            end
            ST_COEF: begin
               w_state_next = ST_RUN;
               w_k_next     = 2'd0;
            end
            ST_RUN: begin
               if (w_issue) begin
                  w_k_next = r_k + 2'd1;
                  if (r_k == K_LAST) begin
                     w_state_next = ST_IDLE;
                  end
               end
            end
            default: begin
               w_state_next = ST_PRIME;
               w_k_next     = 2'd0;
               w_cnt_next   = 1'b0;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_PRIME;
         r_k     <= 2'd0;
         r_cnt   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Sample window: oldest in y0, newest in y2; only reset zeroes it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_y0 <= '0;
         r_y1 <= '0;
         r_y2 <= '0;
      end else if (w_accept) begin
         r_y0 <= r_y1;
         r_y1 <= r_y2;
         r_y2 <= s_data;
      end
   end

   // Phase output register: an issue loads the next phase, acceptance alone empties it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_m_valid <= 1'b0;
         r_phase   <= 2'd0;
      end else if (clear) begin
         r_m_valid <= 1'b0;
      end else if (w_issue) begin
         r_m_valid <= 1'b1;
         r_phase   <= r_k;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign m_valid = r_m_valid;
   assign phase_o = r_phase;

   intpol2_D4_coef #(
      .W      (W),
      .N_bits (N_bits)
   ) u_coef (
      .clk    (clk),
      .rstn   (rstn),
      .i_load (w_load),
      .i_y0   (r_y0),
      .i_y1   (r_y1),
      .i_y2   (r_y2),
      .o_x2   (x2),
      .o_y0   (y0_o),
      .o_c1   (c1_o)
   );

endmodule

// File: tb/tb_intpol2_d4_seq.sv
// Scoreboard bench for intpol2_d4_seq: a window/polynomial reference model
// pushes expected phases on every accepted sample; a monitor pops and checks.
module tb_intpol2_d4_seq;

   localparam int W  = 16;
   localparam int NB = 2;
   localparam int XW = W + NB;
   localparam int CW = W + 5;

   logic                 clk;
   logic                 rstn;
   logic                 clear;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [W-1:0]  s_data;
   logic                 en_xi2;
   logic [1:0]           sel_xi2;
   logic signed [XW-1:0] x2;
   logic                 m_valid;
   logic                 m_ready;
   logic [1:0]           phase_o;
   logic signed [W-1:0]  y0_o;
   logic signed [CW-1:0] c1_o;

   intpol2_d4_seq #(
      .DATAPATH_WIDTH (W),
      .N_bits         (NB)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (clear),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .en_xi2  (en_xi2),
      .sel_xi2 (sel_xi2),
      .x2      (x2),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .phase_o (phase_o),
      .y0_o    (y0_o),
      .c1_o    (c1_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream squared block stand-in, wide enough that it never wraps
   logic signed [63:0] xi2;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) xi2 <= 64'sd0;
      else if (en_xi2) begin
         case (sel_xi2)
            2'b00:   xi2 <= 64'sd0;
            2'b01:   xi2 <= 64'(x2);
            2'b10:   xi2 <= 64'(x2) * 64'sd4;
            default: xi2 <= 64'(x2) * 64'sd9;
         endcase
      end
   end

   typedef struct {
      int     k;
      longint x2;
      longint y0;
      longint c1;
      longint xi2;
   } exp_t;

   exp_t   sb[$];
   longint win[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     acc_cyc  = 0;
   bit     rnd_done = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: p(t) through the last 3 samples, scaled so 32*p(k/4) = 32*y0 + k*c1 + k^2*x2
   function automatic void model_accept(input longint v);
      longint d2, c1;
      win.push_back(v);
      if (win.size() > 3) void'(win.pop_front());
      if (win.size() == 3) begin
         d2 = win[0] - 2 * win[1] + win[2];
         c1 = 8 * (win[1] - win[0]) - 4 * d2;
         for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.k   = k;
            e.x2  = d2;
            e.y0  = win[0];
            e.c1  = c1;
            e.xi2 = longint'(k * k) * d2;
            sb.push_back(e);
         end
      end
   endfunction

   // Monitor: samples 1 time unit after the falling edge, once inputs have settled
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rstn) begin
            if (!en_xi2) check("sel_idle", sel_xi2, 0);
            if (m_valid && !m_ready) check("stall_en", en_xi2, 0);
            if (m_valid && m_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: phase %0d presented, expected none", phase_o);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("txn phase=%0d x2=%0d y0=%0d c1=%0d xi2=%0d", phase_o, x2, y0_o, c1_o, xi2);
                  check("phase", phase_o, e.k);
                  check("xi2", xi2, e.xi2);
                  if (e.k < 3) begin
                     check("x2", x2, e.x2);
                     check("y0", y0_o, e.y0);
                     check("c1", c1_o, e.c1);
                  end
               end
            end
         end
      end
   end

   // Offer one sample; called at a falling edge, returns at a falling edge
   task automatic send(input longint v);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = W'(v);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("s_ready_timeout", 0, 1);
      end else begin
         model_accept(v);
         acc_cyc = cyc;
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while (!(m_valid && phase_o == 2'(ph)) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_phase", (m_valid && phase_o == 2'(ph)) ? 1 : 0, 1);
   endtask

   task automatic expect_quiet(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("no_output", m_valid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rstn    = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_s_ready", s_ready, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_en", en_xi2, 0);
      check("rst_sel", sel_xi2, 0);
      check("rst_x2", x2, 0);
      check("rst_y0", y0_o, 0);
      check("rst_c1", c1_o, 0);
      check("rst_phase", phase_o, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Priming and first polynomial: 10, 20, 40
      send(10);
      send(20);
      expect_quiet(6);
      send(40);
      n = 0;
      while (!m_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", cyc - acc_cyc, 3);
      drain();

      // Follow-on sample: window 20, 40, 40
      send(40);
      drain();

      // Stall phase 1 for 3 cycles (window 40, 40, 50 gives x2 = 10)
      send(50);
      wait_phase(1);
      for (int i = 0; i < 3; i++) begin
         m_ready = 1'b0;
         #1;
         check("stall_valid", m_valid, 1);
         check("stall_phase", phase_o, 1);
         check("stall_xi2", xi2, 10);
         check("stall_en_hold", en_xi2, 0);
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      check("resume_en", en_xi2, 1);
      check("resume_sel", sel_xi2, 2);
      drain();

      // Clear during RUN at k = 2 with a sample offered
      send(60);
      wait_phase(1);
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'sd99;
      #1;
      check("clear_en", en_xi2, 0);
      @(posedge clk);
      #1;
      sb.delete();
      win.delete();
      @(negedge clk);
      clear   = 1'b0;
      s_valid = 1'b0;
      check("clear_m_valid", m_valid, 0);
      check("clear_s_ready", s_ready, 1);

      // Extremes after clear: needs a fresh priming
      send(-32768);
      send(32767);
      expect_quiet(6);
      send(-32768);
      drain();
      check("ext_x2", x2, -131070);
      check("ext_c1", c1_o, 1048560);
      check("ext_y0", y0_o, -32768);

      // Random samples with random backpressure
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send(longint'($urandom_range(0, 65535)) - 32768);
            end
            drain();
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      @(negedge clk);

      // Asynchronous reset in the middle of RUN
      send(longint'($urandom_range(0, 65535)) - 32768);
      wait_phase(1);
      #3;
      rstn = 1'b0;
      #1;
      check("arst_en", en_xi2, 0);
      check("arst_m_valid", m_valid, 0);
      check("arst_x2", x2, 0);
      check("arst_y0", y0_o, 0);
      check("arst_c1", c1_o, 0);
      check("arst_phase", phase_o, 0);
      sb.delete();
      win.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("arst_s_ready", s_ready, 1);
      send(1);
      send(2);
      send(4);
      drain();

      check("final_queue", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
